// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect squash and data-memory
// freeze with a timeout watchdog, driving the pipeline register enables and clears.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             ex_mem_flush,
    output logic             mem_wb_we,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              lu, mw, freeze;

    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mw = mem_req && !mem_ready;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        case (state)
            RUN: begin
                if (mw) begin
                    freeze       = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                // Release cycle falls through to the normal decode with mw forced low
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_W'(TIMEOUT - 1))
                        state_nxt = ERROR;
                    else
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_we    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if (freeze) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign ex_mem_flush = 1'b0;
    assign mem_wb_flush = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= (state_nxt == ERROR);
            if (!pc_we && (state != ERROR) && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk, reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic          ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush, mem_timeout;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
        .ex_mem_we(ex_mem_we), .ex_mem_flush(ex_mem_flush),
        .mem_wb_we(mem_wb_we), .mem_wb_flush(mem_wb_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: consecutive frozen memory cycles, sticky error, stall count
    int consec;
    bit err;
    int stall;

    function automatic logic [8:0] dut_ctl();
        return {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush};
    endfunction

    function automatic bit model_frozen();
        if (err) return 1'b1;
        if (consec > 0) return !mem_ready;
        return mem_req && !mem_ready;
    endfunction

    // Order: pc, if_id we/flush, id_ex we/flush, ex_mem we/flush, mem_wb we/flush
    function automatic logic [8:0] model_ctl();
        bit lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (model_frozen()) return 9'b0_00_00_00_00;
        if (ex_redirect)    return 9'b1_11_11_10_10;
        if (lu)             return 9'b0_00_11_10_10;
        return 9'b1_10_10_10_10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
        ex_redirect = 0; mem_req = 0; mem_ready = 0;
    endtask

    // One clock: check control outputs mid-cycle, advance model at posedge, check registers
    task automatic tick(input string tag);
        logic [8:0] ctl;
        bit frz;
        @(negedge clk);
        ctl = model_ctl();
        frz = model_frozen();
        chk({tag, "_ctl"}, 32'(dut_ctl()), 32'(ctl));
        @(posedge clk);
        if (!err && !ctl[8] && stall < (1 << CW) - 1) stall++;
        if (!err) begin
            if (frz) begin
                consec++;
                if (consec == TO) err = 1'b1;
            end else begin
                consec = 0;
            end
        end
        #1;
        chk({tag, "_stall"}, 32'(stall_cnt), 32'(stall));
        chk({tag, "_tmo"}, 32'(mem_timeout), 32'(err));
    endtask

    // Asynchronous reset: effect must be visible before any clock edge
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        consec = 0; err = 1'b0; stall = 0;
        chk({tag, "_rst_ctl"}, 32'(dut_ctl()), 32'(model_ctl()));
        chk({tag, "_rst_stall"}, 32'(stall_cnt), 32'(0));
        chk({tag, "_rst_tmo"}, 32'(mem_timeout), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int s0;
        idle_inputs();
        consec = 0; err = 1'b0; stall = 0;
        reset = 1'b1;
        #2;
        chk("reset_ctl", 32'(dut_ctl()), 32'(9'b1_10_10_10_10));
        chk("reset_stall", 32'(stall_cnt), 32'(0));
        chk("reset_tmo", 32'(mem_timeout), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        repeat (10) tick("normal");
        chk("normal_stall", 32'(stall_cnt), 32'(0));

        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        tick("loaduse");
        chk("loaduse_stall", 32'(stall_cnt), 32'(1));
        ex_rd = 0; id_rs2 = 0;
        tick("loaduse_x0");

        ex_rd = 5; id_rs2 = 5; ex_redirect = 1;
        tick("redirect");
        chk("redirect_stall", 32'(stall_cnt), 32'(1));

        idle_inputs();
        s0 = stall;
        mem_req = 1; mem_ready = 0;
        repeat (3) tick("memwait");
        mem_ready = 1;
        tick("memrel");
        chk("memwait_stall", 32'(stall_cnt), 32'(s0 + 3));
        idle_inputs();
        tick("after_rel");

        pulse_reset("t5pre");
        mem_req = 1; mem_ready = 0;
        repeat (6) tick("timeout");
        chk("timeout_flag", 32'(mem_timeout), 32'(1));
        mem_ready = 1; ex_redirect = 1;
        tick("err_frozen");
        chk("err_frozen_ctl", 32'(dut_ctl()), 32'(0));
        idle_inputs();
        pulse_reset("t5");

        mem_req = 1; mem_ready = 0;
        tick("midwait1");
        tick("midwait2");
        mem_req = 0;
        #1;
        chk("midwait_frozen", 32'(dut_ctl()), 32'(0));
        pulse_reset("midwait");

        ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        repeat (20) tick("sat");
        chk("sat_stall", 32'(stall_cnt), 32'((1 << CW) - 1));
        idle_inputs();
        pulse_reset("presrand");

        for (int i = 0; i < 400; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 4) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = 1'($urandom_range(0, 1));
            if ((err && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0)
                pulse_reset("rand");
            else
                tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
